lsu: RTL and testbench

Load/store unit answering the execute stage's memory handshake. Accepts one load or store per transaction, performs it on a single-outstanding memory bus, then returns byte/half/word load data (sign- or zero-extended) on the ls_valid/ls_ready channel. Sits between exu and the data memory/AXI bridge in the npc core; replaces the execute stage's "ls_ready tied high" stub.

---
 rtl/lsu.sv | 150 +++++++++++++++
 tb/tb_lsu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: takes one execute-stage memory request at a time, runs it on a
// single-outstanding memory bus and returns extended load data or a completion/error.
module lsu #(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  input  logic                req_is_store,
  input  logic [1:0]          req_size,
  input  logic                req_sign,
  output logic                ls_valid,
  input  logic                ls_ready,
  output logic [DATA_LEN-1:0] load_data,
  output logic                ls_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [DATA_LEN-1:0] mem_addr,
  output logic                mem_wen,
  output logic [DATA_LEN-1:0] mem_wdata,
  output logic [3:0]          mem_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [1:0]          addr_lo_reg;
  logic [1:0]          size_reg;
  logic                sign_reg;
  logic                is_store_reg;
  logic                req_ready_reg;
  logic                mem_req_valid_reg;
  logic                ls_valid_reg;
  logic                ls_err_reg;
  logic [DATA_LEN-1:0] load_data_reg;
  logic [DATA_LEN-1:0] mem_addr_reg;
  logic                mem_wen_reg;
  logic [DATA_LEN-1:0] mem_wdata_reg;
  logic [3:0]          mem_wstrb_reg;

  logic                accept;
  logic                misaligned;
  logic [3:0]          lane_wstrb;
  logic [DATA_LEN-1:0] lane_wdata;
  logic [DATA_LEN-1:0] rdata_shifted;
  logic [DATA_LEN-1:0] load_ext;

  always_comb begin
    accept     = (state_reg == IDLE) && req_valid;
    misaligned = (req_size == 2'd3) ||
                 ((req_size == 2'd1) && req_addr[0]) ||
                 ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_valid)     state_next = misaligned ? DONE : REQ;
      REQ:  if (mem_req_ready) state_next = WAIT;
      WAIT: if (mem_rsp_valid) state_next = DONE;
      DONE: if (ls_ready)      state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Store data is replicated across all lanes so the strobe alone selects the bytes.
  always_comb begin
    lane_wstrb = 4'b0000;
    lane_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        lane_wstrb = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        lane_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_wstrb = 4'b1111;
        lane_wdata = req_wdata;
      end
    endcase
    if (!req_is_store) lane_wstrb = 4'b0000;
  end

  always_comb begin
    rdata_shifted = mem_rdata >> {addr_lo_reg, 3'b000};
    case (size_reg)
      2'd0:    load_ext = {{(DATA_LEN-8){sign_reg & rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'd1:    load_ext = {{(DATA_LEN-16){sign_reg & rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      addr_lo_reg       <= 2'b00;
      size_reg          <= 2'b00;
      sign_reg          <= 1'b0;
      is_store_reg      <= 1'b0;
      req_ready_reg     <= 1'b0;
      mem_req_valid_reg <= 1'b0;
      ls_valid_reg      <= 1'b0;
      ls_err_reg        <= 1'b0;
      load_data_reg     <= '0;
      mem_addr_reg      <= '0;
      mem_wen_reg       <= 1'b0;
      mem_wdata_reg     <= '0;
      mem_wstrb_reg     <= 4'b0000;
    end else begin
      state_reg         <= state_next;
      // Handshake flags follow the next state so every output leaves a flop.
      req_ready_reg     <= (state_next == IDLE);
      mem_req_valid_reg <= (state_next == REQ);
      ls_valid_reg      <= (state_next == DONE);
      if (accept) begin
        addr_lo_reg   <= req_addr[1:0];
        size_reg      <= req_size;
        sign_reg      <= req_sign;
        is_store_reg  <= req_is_store;
        ls_err_reg    <= misaligned;
        load_data_reg <= '0;
        if (!misaligned) begin
          mem_addr_reg  <= {req_addr[DATA_LEN-1:2], 2'b00};
          mem_wen_reg   <= req_is_store;
          mem_wdata_reg <= lane_wdata;
          mem_wstrb_reg <= lane_wstrb;
        end
      end
      if ((state_reg == WAIT) && mem_rsp_valid && !is_store_reg)
        load_data_reg <= load_ext;
    end
  end

  assign req_ready     = req_ready_reg;
  assign mem_req_valid = mem_req_valid_reg;
  assign ls_valid      = ls_valid_reg;
  assign ls_err        = ls_err_reg;
  assign load_data     = load_data_reg;
  assign mem_addr      = mem_addr_reg;
  assign mem_wen       = mem_wen_reg;
  assign mem_wdata     = mem_wdata_reg;
  assign mem_wstrb     = mem_wstrb_reg;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: loads, stores, back-pressure, misaligned accesses and mid-flight reset.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_sign;
  logic        ls_valid, ls_ready;
  logic [31:0] load_data;
  logic        ls_err;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_req_cnt = 0;

  lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_is_store(req_is_store), .req_size(req_size),
    .req_sign(req_sign), .ls_valid(ls_valid), .ls_ready(ls_ready),
    .load_data(load_data), .ls_err(ls_err), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_req_valid) mem_req_cnt <= mem_req_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One transaction; expectations are hand-computed by the caller.
  task automatic txn(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic st, input logic [1:0] size, input logic sgn,
                     input logic [31:0] rdata, input int req_stall, input int rsp_delay,
                     input int ls_stall, input logic exp_err, input logic [31:0] exp_addr,
                     input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                     input logic [31:0] exp_data, input int exp_lat);
    int acc;
    int cnt0;
    check({name, " idle req_ready"}, {31'b0, req_ready}, 32'd1);
    cnt0 = mem_req_cnt;
    req_addr = addr; req_wdata = wdata; req_is_store = st; req_size = size; req_sign = sgn;
    req_valid = 1'b1;
    acc = cyc;
    tick();
    req_valid = 1'b0;
    req_addr = 32'hxxxx_xxxx; req_wdata = 32'h5A5A_5A5A;
    if (!exp_err) begin
      for (int i = 0; i <= req_stall; i++) begin
        check({name, " mem_req_valid"}, {31'b0, mem_req_valid}, 32'd1);
        check({name, " mem_addr"}, mem_addr, exp_addr);
        check({name, " mem_wen"}, {31'b0, mem_wen}, {31'b0, st});
        check({name, " mem_wstrb"}, {28'b0, mem_wstrb}, {28'b0, exp_wstrb});
        if (st) check({name, " mem_wdata"}, mem_wdata, exp_wdata);
        check({name, " req_ready busy"}, {31'b0, req_ready}, 32'd0);
        mem_rsp_valid = 1'b1; mem_rdata = 32'h1111_2222;
        if (i == req_stall) mem_req_ready = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
      end
      for (int i = 0; i <= rsp_delay; i++) begin
        check({name, " wait mem_req_valid"}, {31'b0, mem_req_valid}, 32'd0);
        check({name, " wait ls_valid"}, {31'b0, ls_valid}, 32'd0);
        mem_req_ready = 1'b1;
        if (i == rsp_delay) begin
          mem_rsp_valid = 1'b1; mem_rdata = rdata;
        end
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rdata = 32'h3C3C_C3C3;
      end
    end
    check({name, " latency"}, cyc - acc, exp_lat);
    for (int i = 0; i <= ls_stall; i++) begin
      check({name, " ls_valid"}, {31'b0, ls_valid}, 32'd1);
      check({name, " load_data"}, load_data, exp_data);
      check({name, " ls_err"}, {31'b0, ls_err}, {31'b0, exp_err});
      check({name, " req_ready done"}, {31'b0, req_ready}, 32'd0);
      if (i == ls_stall) ls_ready = 1'b1;
      tick();
      ls_ready = 1'b0;
    end
    check({name, " ls_valid drop"}, {31'b0, ls_valid}, 32'd0);
    check({name, " req_ready back"}, {31'b0, req_ready}, 32'd1);
    if (exp_err) check({name, " no mem traffic"}, mem_req_cnt, cnt0);
    $display("txn %-12s addr=0x%08h st=%0d size=%0d load_data=0x%08h err=%0d", name, addr, st,
             size, exp_data, exp_err);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_is_store = 1'b0;
    req_size = 2'd0; req_sign = 1'b0; ls_ready = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("rst req_ready", {31'b0, req_ready}, 32'd0);
    check("rst ls_valid", {31'b0, ls_valid}, 32'd0);
    check("rst mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst mem_wen", {31'b0, mem_wen}, 32'd0);
    check("rst mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst load_data", load_data, 32'd0);
    check("rst ls_err", {31'b0, ls_err}, 32'd0);
    rst = 1'b0;
    tick();
    check("post-rst req_ready", {31'b0, req_ready}, 32'd1);

    //   name        addr          wdata         st    sz    sg    rdata        rs rd ls err exp_addr      strb     exp_wdata     exp_data     lat
    txn("lw",        32'h8000_0004, 32'h0,        1'b0, 2'd2, 1'b0, 32'hDEADBEEF, 0, 0, 0, 1'b0, 32'h8000_0004, 4'b0000, 32'h0,        32'hDEADBEEF, 3);
    txn("lb",        32'h8000_0003, 32'h0,        1'b0, 2'd0, 1'b1, 32'h80FF7F01, 0, 0, 0, 1'b0, 32'h8000_0000, 4'b0000, 32'h0,        32'hFFFFFF80, 3);
    txn("lbu",       32'h8000_0003, 32'h0,        1'b0, 2'd0, 1'b0, 32'h80FF7F01, 0, 0, 0, 1'b0, 32'h8000_0000, 4'b0000, 32'h0,        32'h00000080, 3);
    txn("lbu1",      32'h8000_0001, 32'h0,        1'b0, 2'd0, 1'b0, 32'h80FF7F01, 0, 0, 0, 1'b0, 32'h8000_0000, 4'b0000, 32'h0,        32'h0000007F, 3);
    txn("lh",        32'h8000_0002, 32'h0,        1'b0, 2'd1, 1'b1, 32'h80FF7F01, 0, 0, 0, 1'b0, 32'h8000_0000, 4'b0000, 32'h0,        32'hFFFF80FF, 3);
    txn("lh0",       32'h8000_0000, 32'h0,        1'b0, 2'd1, 1'b1, 32'h80FF7F01, 0, 0, 0, 1'b0, 32'h8000_0000, 4'b0000, 32'h0,        32'h00007F01, 3);
    txn("lhu",       32'h8000_0002, 32'h0,        1'b0, 2'd1, 1'b0, 32'h80FF7F01, 0, 0, 0, 1'b0, 32'h8000_0000, 4'b0000, 32'h0,        32'h000080FF, 3);
    txn("sb",        32'h8000_0001, 32'hFFFFFFAB, 1'b1, 2'd0, 1'b0, 32'hFFFFFFFF, 0, 0, 0, 1'b0, 32'h8000_0000, 4'b0010, 32'hABABABAB, 32'h0,        3);
    txn("sh",        32'h8000_0002, 32'h55551234, 1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 0, 0, 0, 1'b0, 32'h8000_0000, 4'b1100, 32'h12341234, 32'h0,        3);
    txn("sw",        32'h8000_0008, 32'hCAFEF00D, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFF, 0, 1, 0, 1'b0, 32'h8000_0008, 4'b1111, 32'hCAFEF00D, 32'h0,        4);
    txn("lw-bp",     32'h8000_0010, 32'h0,        1'b0, 2'd2, 1'b0, 32'h01234567, 4, 3, 2, 1'b0, 32'h8000_0010, 4'b0000, 32'h0,        32'h01234567, 10);
    txn("lw-mis",    32'h8000_0002, 32'h0,        1'b0, 2'd2, 1'b0, 32'h0,        0, 0, 0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0,        1);
    txn("lh-mis",    32'h8000_0001, 32'h0,        1'b0, 2'd1, 1'b1, 32'h0,        0, 0, 0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0,        1);
    txn("size3",     32'h8000_0000, 32'h0,        1'b0, 2'd3, 1'b0, 32'h0,        0, 0, 1, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0,        1);
    txn("sh-mis",    32'h8000_0003, 32'h1234,     1'b1, 2'd1, 1'b0, 32'h0,        0, 0, 0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0,        1);

    // Reset while waiting for the read response; the late response must be dropped.
    req_addr = 32'h8000_0020; req_is_store = 1'b0; req_size = 2'd2; req_sign = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("rstwait mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    rst = 1'b1;
    tick();
    check("rstwait ls_valid", {31'b0, ls_valid}, 32'd0);
    check("rstwait req_ready", {31'b0, req_ready}, 32'd0);
    check("rstwait load_data", load_data, 32'd0);
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    tick();
    mem_rsp_valid = 1'b0;
    check("stray ls_valid", {31'b0, ls_valid}, 32'd0);
    check("stray req_ready", {31'b0, req_ready}, 32'd1);
    tick();
    check("stray ls_valid later", {31'b0, ls_valid}, 32'd0);
    check("stray load_data", load_data, 32'd0);
    $display("txn %-12s reset in WAIT, stray response dropped", "rst-wait");
    txn("lw-after",  32'h8000_0024, 32'h0,        1'b0, 2'd2, 1'b0, 32'h13579BDF, 0, 0, 0, 1'b0, 32'h8000_0024, 4'b0000, 32'h0,        32'h13579BDF, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
